// File: rtl/reg_tag_pipe.sv
// Destination-tag pipeline for DEPTH stages after decode: produces forwarding
// selects, a load-use hazard request, the regfile write tag and a stall counter.
module reg_tag_pipe #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned ALU_RDY  = 2,
  parameter int unsigned LOAD_RDY = 3,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*REG_W-1:0]   src_tag_D,
  input  logic [NUM_SRC-1:0]         src_used_D,
  input  logic [REG_W-1:0]           dst_tag_D,
  input  logic                       dst_link_D,
  input  logic                       dst_wr_D,
  input  logic                       dst_load_D,
  input  logic                       valid_D,
  input  logic [DEPTH-1:0]           stall,
  input  logic [DEPTH-1:0]           flush,
  input  logic                       cnt_clr,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       hazard_stall,
  output logic                       wr_en_last,
  output logic [REG_W-1:0]           wr_tag_last,
  output logic [CNT_W-1:0]           stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic             load;
    logic [REG_W-1:0] tag;
  } entry_t;

  entry_t [DEPTH-1:0] stg_q;
  entry_t [DEPTH-1:0] stg_d;
  entry_t             d_entry;
  entry_t [DEPTH:0]   prev_e;
  logic   [DEPTH:0]   prev_stall;

  assign d_entry.valid = valid_D;
  assign d_entry.wr    = dst_wr_D;
  assign d_entry.load  = dst_load_D;
  assign d_entry.tag   = dst_link_D ? {REG_W{1'b1}} : dst_tag_D;

  // Index k of these vectors describes the stage feeding stage index k (D at 0).
  assign prev_e     = {stg_q, d_entry};
  assign prev_stall = {stall, 1'b0};

  // Stage advance: flush > hold > auto-bubble behind a stalled stage > shift.
  always_comb begin
    stg_d = stg_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (flush[k])
        stg_d[k] = '0;
      else if (stall[k])
        stg_d[k] = stg_q[k];
      else if (prev_stall[k])
        stg_d[k] = '0;
      else
        stg_d[k] = prev_e[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stg_q <= '0;
    else
      stg_q <= stg_d;
  end

  // Youngest matching stage per source decides forward vs. hazard.
  always_comb begin
    logic             hit;
    logic             rdy;
    logic             zero_ok;
    logic [REG_W-1:0] stag;
    fwd_sel      = '0;
    hazard_stall = 1'b0;
    hit          = 1'b0;
    rdy          = 1'b0;
    zero_ok      = 1'b0;
    stag         = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      hit     = 1'b0;
      stag    = src_tag_D[s*REG_W +: REG_W];
      zero_ok = !((ZERO_REG != 0) && (stag == '0));
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!hit && src_used_D[s] && zero_ok && stg_q[k].valid && stg_q[k].wr &&
            (stg_q[k].tag == stag)) begin
          hit = 1'b1;
          rdy = stg_q[k].load ? ((k + 1) >= LOAD_RDY) : ((k + 1) >= ALU_RDY);
          if (rdy)
            fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
          else
            hazard_stall = 1'b1;
        end
      end
    end
  end

  assign wr_tag_last = stg_q[DEPTH-1].tag;
  assign wr_en_last  = stg_q[DEPTH-1].valid && stg_q[DEPTH-1].wr &&
                       !((ZERO_REG != 0) && (stg_q[DEPTH-1].tag == '0));

  // Saturating count of hazard cycles; clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (cnt_clr)
      stall_cnt <= '0;
    else if (hazard_stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_reg_tag_pipe.sv
// Self-checking bench for reg_tag_pipe: directed scenarios plus random traffic
// compared against a list-based reference of the tag pipeline.
module tb_reg_tag_pipe;

  localparam int REG_W = 5;
  localparam int DEPTH = 3;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;
  localparam int unsigned CNT_MAX = 65535;

  logic             clk = 1'b0;
  logic             reset;
  logic [2*REG_W-1:0] src_tag_D;
  logic [1:0]       src_used_D;
  logic [REG_W-1:0] dst_tag_D;
  logic             dst_link_D, dst_wr_D, dst_load_D, valid_D;
  logic [DEPTH-1:0] stall, flush;
  logic             cnt_clr;
  logic [2*SEL_W-1:0] fwd_sel;
  logic             hazard_stall, wr_en_last;
  logic [REG_W-1:0] wr_tag_last;
  logic [CNT_W-1:0] stall_cnt;

  reg_tag_pipe dut (
    .clk(clk), .reset(reset), .src_tag_D(src_tag_D), .src_used_D(src_used_D),
    .dst_tag_D(dst_tag_D), .dst_link_D(dst_link_D), .dst_wr_D(dst_wr_D),
    .dst_load_D(dst_load_D), .valid_D(valid_D), .stall(stall), .flush(flush),
    .cnt_clr(cnt_clr), .fwd_sel(fwd_sel), .hazard_stall(hazard_stall),
    .wr_en_last(wr_en_last), .wr_tag_last(wr_tag_last), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       w;
    bit       l;
    bit [4:0] t;
  } ent_t;

  ent_t        m [0:DEPTH];
  int unsigned mcnt;
  int unsigned e_sel [2];
  bit          e_haz;
  bit          e_wen;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k <= DEPTH; k++) m[k] = '{0, 0, 0, 5'd0};
    mcnt = 0;
  endtask

  // Expected outputs: scan stages from youngest, first match decides.
  task automatic model_outputs();
    bit [4:0] st;
    bit       found;
    e_haz = 0;
    for (int s = 0; s < 2; s++) begin
      e_sel[s] = 0;
      found = 0;
      st = src_tag_D[s*REG_W +: REG_W];
      if (src_used_D[s] && st != 0) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (!found && m[k].v && m[k].w && m[k].t == st) begin
            found = 1;
            if (k >= (m[k].l ? 3 : 2)) e_sel[s] = k;
            else e_haz = 1;
          end
        end
      end
    end
    e_wen = m[DEPTH].v && m[DEPTH].w && m[DEPTH].t != 0;
  endtask

  task automatic settle();
    #1;
    model_outputs();
    check("fwd_sel0", 32'(fwd_sel[1:0]), e_sel[0]);
    check("fwd_sel1", 32'(fwd_sel[3:2]), e_sel[1]);
    check("hazard", 32'(hazard_stall), 32'(e_haz));
    check("wr_en_last", 32'(wr_en_last), 32'(e_wen));
    check("wr_tag_last", 32'(wr_tag_last), 32'(m[DEPTH].t));
    check("stall_cnt", 32'(stall_cnt), mcnt);
  endtask

  task automatic advance();
    ent_t     old [0:DEPTH];
    bit [3:0] pst;
    @(posedge clk);
    old = m;
    old[0] = '{valid_D, dst_wr_D, dst_load_D, dst_link_D ? 5'd31 : dst_tag_D};
    pst = {stall, 1'b0};
    for (int k = 1; k <= DEPTH; k++) begin
      if (flush[k-1])    m[k] = '{0, 0, 0, 5'd0};
      else if (stall[k-1]) m[k] = old[k];
      else if (pst[k-1]) m[k] = '{0, 0, 0, 5'd0};
      else               m[k] = old[k-1];
    end
    if (cnt_clr) mcnt = 0;
    else if (e_haz && mcnt < CNT_MAX) mcnt++;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle();
    src_tag_D = '0; src_used_D = '0; dst_tag_D = '0; dst_link_D = 0;
    dst_wr_D = 0; dst_load_D = 0; valid_D = 0; stall = '0; flush = '0; cnt_clr = 0;
  endtask

  task automatic push(input bit [4:0] t, input bit ld);
    idle();
    valid_D = 1; dst_wr_D = 1; dst_load_D = ld; dst_tag_D = t;
    step();
    idle();
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_clear();
    check("rst_fwd_sel", 32'(fwd_sel), 0);
    check("rst_hazard", 32'(hazard_stall), 0);
    check("rst_wr_en", 32'(wr_en_last), 0);
    check("rst_wr_tag", 32'(wr_tag_last), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    model_clear();
    @(negedge clk);
    do_reset();

    // r5 ALU result: not forwardable from E, forwardable from M
    push(5'd5, 0);
    src_tag_D[4:0] = 5'd5; src_used_D = 2'b01;
    settle(); check("alu_E_hazard", 32'(hazard_stall), 1);
    advance();
    settle(); check("alu_M_fwd", 32'(fwd_sel[1:0]), 2);
    check("alu_M_nohaz", 32'(hazard_stall), 0);
    advance();

    // r8 load: hazard in M, forward and write from W
    push(5'd8, 1);
    advance();
    src_tag_D[9:5] = 5'd8; src_used_D = 2'b10;
    settle(); check("ld_M_hazard", 32'(hazard_stall), 1);
    advance();
    settle(); check("ld_W_fwd", 32'(fwd_sel[3:2]), 3);
    check("ld_W_wren", 32'(wr_en_last), 1);
    check("ld_W_tag", 32'(wr_tag_last), 8);
    advance();

    // two r3 producers: youngest (E) decides, then E flushed
    push(5'd3, 0);
    push(5'd3, 0);
    src_tag_D[4:0] = 5'd3; src_used_D = 2'b01;
    settle(); check("young_hazard", 32'(hazard_stall), 1);
    flush = 3'b001;
    advance();
    flush = '0;
    settle(); check("young_flush_fwd", 32'(fwd_sel[1:0]), 2);
    advance();

    // r0 writer never matches nor writes
    push(5'd0, 0);
    src_tag_D = '0; src_used_D = 2'b11;
    advance();
    settle(); check("zero_fwd", 32'(fwd_sel), 0);
    check("zero_haz", 32'(hazard_stall), 0);
    advance();
    settle(); check("zero_wren", 32'(wr_en_last), 0);
    advance();

    // stall E two cycles: bubbles into M, W drains
    push(5'd10, 0); push(5'd11, 0); push(5'd12, 0);
    stall = 3'b001; valid_D = 1; dst_wr_D = 1; dst_tag_D = 5'd13;
    step();
    settle(); check("stall1_wtag", 32'(wr_tag_last), 11);
    check("stall1_wren", 32'(wr_en_last), 1);
    advance();
    src_tag_D[4:0] = 5'd12; src_used_D = 2'b01;
    settle(); check("stall2_wren", 32'(wr_en_last), 0);
    check("stall_visible", 32'(hazard_stall), 1);
    flush = 3'b001;
    advance();
    flush = '0; stall = '0;
    settle(); check("flush_wins", 32'(hazard_stall), 0);
    advance();

    // link register write reaches W as tag 31
    idle(); valid_D = 1; dst_wr_D = 1; dst_link_D = 1; dst_tag_D = 5'd4;
    step(); idle(); advance(); advance();
    settle(); check("link_tag", 32'(wr_tag_last), 31);
    advance();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      src_tag_D  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      src_used_D = 2'($urandom);
      dst_tag_D  = 5'($urandom_range(0, 7));
      dst_link_D = ($urandom_range(0, 15) == 0);
      dst_wr_D   = ($urandom_range(0, 3) != 0);
      dst_load_D = ($urandom_range(0, 2) == 0);
      valid_D    = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < DEPTH; b++) begin
        stall[b] = ($urandom_range(0, 7) == 0);
        flush[b] = ($urandom_range(0, 15) == 0);
      end
      cnt_clr = ($urandom_range(0, 49) == 0);
      step();
    end

    // mid-run reset with full stages
    push(5'd1, 0); push(5'd2, 1); push(5'd6, 0);
    do_reset();
    idle();
    settle();

    // counter saturation: load held in E keeps hazard asserted
    push(5'd8, 1);
    stall = 3'b001; src_tag_D[4:0] = 5'd8; src_used_D = 2'b01;
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step();
    settle(); check("cnt_sat", 32'(stall_cnt), 32'hFFFF);
    check("sat_hazard", 32'(hazard_stall), 1);
    cnt_clr = 1;
    advance();
    cnt_clr = 0;
    settle(); check("cnt_clr", 32'(stall_cnt), 0);
    advance();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
